// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
//   Shared types and constants for the March C- BIST engine.
//   - march_elem_e : march element index M0..M5
//   - bist_state_e : controller FSM states
//   - elem_cfg_t   : per-element description (direction, read expectation,
//                    write presence and write pattern)
//   - ELEM_TABLE   : the March C- algorithm expressed as a table
//   - next_elem / first_state : small helpers used by the controller
package ram_bist_pkg;

  localparam int ELEM_CNT = 6;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } march_elem_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CMP,
    WR,
    DONE
  } bist_state_e;

  // One march element. Patterns are a single bit replicated across the
  // whole data word (0 -> all zeros, 1 -> all ones).
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_pat;
    logic has_write;
    logic write_pat;
  } elem_cfg_t;

  // March C-, field order {dir_down, has_read, read_pat, has_write, write_pat}:
  //   M0 up(w0), M1 up(r0,w1), M2 up(r1,w0),
  //   M3 down(r0,w1), M4 down(r1,w0), M5 up(r0)
  localparam elem_cfg_t ELEM_TABLE [ELEM_CNT] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  // Successor element; saturates at M5 so the table is never indexed
  // out of range even though the controller stops after M5.
  function automatic march_elem_e next_elem(input march_elem_e e);
    march_elem_e n;
    n = (e == M5) ? M5 : march_elem_e'(e + 3'd1);
    return n;
  endfunction

  // Every address visit of an element opens with its read if it has one,
  // otherwise directly with the write.
  function automatic bist_state_e first_state(input march_elem_e e);
    bist_state_e s;
    s = ELEM_TABLE[e].has_read ? RD : WR;
    return s;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if
//   Bus between the BIST engine and the single-port RAM core.
//   - bist_cs    : chip select, active high
//   - bist_we    : 1 = write, 0 = read (also the data-pad output enable)
//   - bist_addr  : word address
//   - bist_wdata : write data
//   - ram_rdata  : read data returned by the RAM core
//   master = BIST engine, slave = RAM side.
interface ram_bist_ctrl_if #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
);

  logic                 bist_cs;
  logic                 bist_we;
  logic [ADDRWIDTH-1:0] bist_addr;
  logic [DATAWIDTH-1:0] bist_wdata;
  logic [DATAWIDTH-1:0] ram_rdata;

  modport master (
    output bist_cs,
    output bist_we,
    output bist_addr,
    output bist_wdata,
    input  ram_rdata
  );

  modport slave (
    input  bist_cs,
    input  bist_we,
    input  bist_addr,
    input  bist_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
//   Up/down address counter for the march elements.
//   - clk, rst_n : clock, asynchronous active-low reset
//   - load_up    : load address 0 and count upwards from now on
//   - load_down  : load address SIZE-1 and count downwards from now on
//   - step       : move one address in the loaded direction
//   - addr       : current address
//   - last       : current address is the final one of the element
//   The element spans 0..SIZE-1, which need not fill the address space.
module ram_bist_addr_gen #(
  parameter int ADDRWIDTH = 4,
  parameter int SIZE      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_up,
  input  logic                 load_down,
  input  logic                 step,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 last
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(SIZE - 1);
  localparam logic [ADDRWIDTH-1:0] ONE       = ADDRWIDTH'(1);

  logic down_q;

  // Direction is latched at load time so the controller only has to say
  // "step" while walking an element. Loads win over a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load_up) begin
      addr   <= '0;
      down_q <= 1'b0;
    end else if (load_down) begin
      addr   <= LAST_ADDR;
      down_q <= 1'b1;
    end else if (step) begin
      addr <= down_q ? (addr - ONE) : (addr + ONE);
    end
  end

  assign last = down_q ? (addr == '0) : (addr == LAST_ADDR);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//   March C- built-in self-test engine for the single-port RAM core.
//   - clk, rst_n : core clock, asynchronous active-low reset
//   - start      : level request, only looked at while idle or done
//   - bus        : RAM bus (cs/we/addr/wdata out, rdata in)
//   - busy       : test in progress
//   - done       : test finished, held until the next start
//   - fail       : a mismatch was found (meaningful while done)
//   - fail_elem  : march element of the first mismatch
//   - fail_addr  : address of the first mismatch
//   - fail_data  : read data XOR expected data at the first mismatch
//   The engine stops at the first mismatch and holds the diagnostics.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  ram_bist_ctrl_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [2:0]           fail_elem,
  output logic [ADDRWIDTH-1:0] fail_addr,
  output logic [DATAWIDTH-1:0] fail_data
);

  localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  bist_state_e          state_q, state_d;
  march_elem_e          elem_q, elem_d;
  march_elem_e          nxt_elem;
  logic [LAT_W-1:0]     lat_q;
  logic                 lat_done;
  logic                 load_up, load_down, step;
  logic                 advance;
  logic                 diag_clr, diag_set;
  logic [ADDRWIDTH-1:0] addr;
  logic                 last;
  logic [DATAWIDTH-1:0] expect_word;
  logic [DATAWIDTH-1:0] syndrome;
  logic                 mismatch;
  logic                 ram_active;

  ram_bist_addr_gen #(
    .ADDRWIDTH(ADDRWIDTH),
    .SIZE     (SIZE)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_up  (load_up),
    .load_down(load_down),
    .step     (step),
    .addr     (addr),
    .last     (last)
  );

  assign nxt_elem    = next_elem(elem_q);
  assign lat_done    = (lat_q == LAT_LAST);
  assign expect_word = {DATAWIDTH{ELEM_TABLE[elem_q].read_pat}};
  assign syndrome    = bus.ram_rdata ^ expect_word;
  assign mismatch    = |syndrome;

  // State and current element registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= M0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  // Read-latency counter: counts the cycles spent in RD so the compare
  // happens exactly when the RAM has delivered the data. It sits at zero
  // outside RD, so every visit to RD starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state_q == RD && !lat_done) begin
      lat_q <= lat_q + LAT_ONE;
    end else begin
      lat_q <= '0;
    end
  end

  // Next-state logic. "advance" means the current address of the element
  // is finished: either step to the next address, move to the next
  // element's start address, or finish after M5.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    load_up   = 1'b0;
    load_down = 1'b0;
    step      = 1'b0;
    advance   = 1'b0;
    diag_clr  = 1'b0;
    diag_set  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          elem_d   = M0;
          load_up  = 1'b1;
          diag_clr = 1'b1;
          state_d  = first_state(M0);
        end
      end
      RD: begin
        if (lat_done) begin
          state_d = CMP;
        end
      end
      CMP: begin
        if (mismatch) begin
          diag_set = 1'b1;
          state_d  = DONE;
        end else if (ELEM_TABLE[elem_q].has_write) begin
          state_d = WR;
        end else begin
          advance = 1'b1;
        end
      end
      WR: begin
        advance = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (!last) begin
        step    = 1'b1;
        state_d = first_state(elem_q);
      end else if (elem_q == M5) begin
        state_d = DONE;
      end else begin
        elem_d = nxt_elem;
        if (ELEM_TABLE[nxt_elem].dir_down) begin
          load_down = 1'b1;
        end else begin
          load_up = 1'b1;
        end
        state_d = first_state(nxt_elem);
      end
    end
  end

  // First-failure diagnostics: cleared when a run starts, captured once
  // on the failing compare, then held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (diag_clr) begin
      fail      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (diag_set) begin
      fail      <= 1'b1;
      fail_elem <= elem_q;
      fail_addr <= addr;
      fail_data <= syndrome;
    end
  end

  // The RAM is only touched in RD/CMP/WR; everything on the bus is forced
  // to zero otherwise so the pads sit quiet in IDLE and DONE.
  assign ram_active     = (state_q == RD) || (state_q == CMP) || (state_q == WR);
  assign busy           = ram_active;
  assign done           = (state_q == DONE);
  assign bus.bist_cs    = ram_active;
  assign bus.bist_we    = (state_q == WR);
  assign bus.bist_addr  = ram_active ? addr : '0;
  assign bus.bist_wdata = (state_q == WR) ? {DATAWIDTH{ELEM_TABLE[elem_q].write_pat}} : '0;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
//   Two engines: dut0 with defaults (SIZE=16, RD_LAT=1) in front of a RAM
//   model with injectable stuck-at and write-aliasing faults, and dut1 with
//   SIZE=12, RD_LAT=2 in front of a fault-free two-stage-latency RAM model.
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;

  always #5 clk = ~clk;

  logic       busy0, done0, fail0;
  logic [2:0] fail_elem0;
  logic [3:0] fail_addr0;
  logic [7:0] fail_data0;
  logic       busy1, done1, fail1;
  logic [2:0] fail_elem1;
  logic [3:0] fail_addr1;
  logic [7:0] fail_data1;

  ram_bist_ctrl_if #(.ADDRWIDTH(4), .DATAWIDTH(8)) ram0 ();
  ram_bist_ctrl_if #(.ADDRWIDTH(4), .DATAWIDTH(8)) ram1 ();

  ram_bist_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(16), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(ram0.master),
    .busy(busy0), .done(done0), .fail(fail0),
    .fail_elem(fail_elem0), .fail_addr(fail_addr0), .fail_data(fail_data0)
  );

  ram_bist_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(12), .RD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(ram1.master),
    .busy(busy1), .done(done1), .fail(fail1),
    .fail_elem(fail_elem1), .fail_addr(fail_addr1), .fail_data(fail_data1)
  );

  // Fault description: 0 = none, 1 = stuck-at bit, 2 = writes to a_src also land in a_dst
  int         fault_kind = 0;
  logic [3:0] f_addr = '0;
  logic [2:0] f_bit = '0;
  logic       f_val = 1'b0;
  logic [3:0] a_src = '0;
  logic [3:0] a_dst = '0;

  // March C- as plain bit tables indexed by element number
  localparam logic [5:0] EL_DOWN  = 6'b011000;
  localparam logic [5:0] EL_HASRD = 6'b111110;
  localparam logic [5:0] EL_RDVAL = 6'b010100;
  localparam logic [5:0] EL_HASWR = 6'b011111;
  localparam logic [5:0] EL_WRVAL = 6'b001010;

  int n_checks = 0;
  int n_errors = 0;
  int viol = 0;

  function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fault_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  // RAM model 0: one-cycle read latency, fault injection on the write path
  logic [7:0] mem0 [16];
  logic [7:0] rd0 = '0;
  always @(posedge clk) begin
    if (ram0.bist_cs) begin
      if (ram0.bist_we) begin
        mem0[ram0.bist_addr] <= faulty(ram0.bist_addr, ram0.bist_wdata);
        if (fault_kind == 2 && ram0.bist_addr == a_src)
          mem0[a_dst] <= faulty(a_dst, ram0.bist_wdata);
      end else begin
        rd0 <= mem0[ram0.bist_addr];
      end
    end
  end
  assign ram0.ram_rdata = rd0;

  // RAM model 1: two-cycle read latency, fault-free
  logic [7:0] mem1 [16];
  logic [7:0] p1a = '0;
  logic [7:0] p1b = '0;
  always @(posedge clk) begin
    if (ram1.bist_cs && ram1.bist_we) mem1[ram1.bist_addr] <= ram1.bist_wdata;
    if (ram1.bist_cs && !ram1.bist_we) p1a <= mem1[ram1.bist_addr];
    p1b <= p1a;
  end
  assign ram1.ram_rdata = p1b;

  // Bus rules and dut1 access trace, sampled away from the active edge
  bit         trace_on = 1'b0;
  logic [4:0] act_trace[$];
  logic [4:0] exp_trace[$];
  always @(negedge clk) begin
    if (!ram0.bist_cs && ram0.bist_we) viol++;
    if (!ram0.bist_we && ram0.bist_wdata != 8'h00) viol++;
    if (!ram1.bist_cs && ram1.bist_we) viol++;
    if (!ram1.bist_we && ram1.bist_wdata != 8'h00) viol++;
    if (trace_on && ram1.bist_cs) act_trace.push_back({ram1.bist_we, ram1.bist_addr});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    int         kind;
    logic [3:0] fa;
    logic [2:0] fb;
    logic       fv;
    logic [3:0] src;
    logic [3:0] dst;
    logic       e_fail;
    logic [2:0] e_elem;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    int         e_cycles;
  } vec_t;

  task automatic applyStimulus(input vec_t v);
    fault_kind = v.kind;
    f_addr     = v.fa;
    f_bit      = v.fb;
    f_val      = v.fv;
    a_src      = v.src;
    a_dst      = v.dst;
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 0) start0 = v;
    else start1 = v;
  endtask

  // Start a run and count busy cycles until done. With hold set, start is
  // left high on return; pulse_at re-pulses start after that many busy cycles.
  task automatic runBist(input int which, input bit hold, input int pulse_at, output int cycles);
    bit timed_out;
    bit d, b;
    cycles    = 0;
    timed_out = 1'b1;
    @(negedge clk);
    setStart(which, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d = (which == 0) ? done0 : done1;
      b = (which == 0) ? busy0 : busy1;
      if (d) begin
        timed_out = 1'b0;
        break;
      end
      if (b) cycles++;
      if (!hold) setStart(which, (cycles == pulse_at));
    end
    checkOutput("run_timeout", {31'd0, timed_out}, 32'd0);
  endtask

  // Reference: walk March C- over an array with the same fault definition
  task automatic refMarch(input int size, input int rd_lat, output bit r_fail, output int r_elem,
                          output int r_addr, output logic [7:0] r_data, output int r_cycles);
    logic [7:0] rmem [16];
    r_fail = 1'b0; r_elem = 0; r_addr = 0; r_data = '0; r_cycles = 0;
    for (int i = 0; i < 16; i++) rmem[i] = 8'h5A;
    for (int e = 0; e < 6 && !r_fail; e++) begin
      for (int k = 0; k < size && !r_fail; k++) begin
        int a;
        logic [7:0] ev, wv;
        a = EL_DOWN[e] ? size - 1 - k : k;
        if (EL_HASRD[e]) begin
          ev = EL_RDVAL[e] ? 8'hFF : 8'h00;
          r_cycles += rd_lat + 1;
          if (rmem[a] !== ev) begin
            r_fail = 1'b1; r_elem = e; r_addr = a; r_data = rmem[a] ^ ev;
          end
        end
        if (!r_fail && EL_HASWR[e]) begin
          wv = EL_WRVAL[e] ? 8'hFF : 8'h00;
          r_cycles += 1;
          rmem[a] = faulty(4'(a), wv);
          if (fault_kind == 2 && 4'(a) == a_src) rmem[a_dst] = faulty(a_dst, wv);
        end
      end
    end
  endtask

  // Expected per-cycle {we, addr} bus trace of a fault-free run
  task automatic buildTrace(input int size, input int rd_lat);
    exp_trace.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < size; k++) begin
        int a;
        a = EL_DOWN[e] ? size - 1 - k : k;
        if (EL_HASRD[e]) for (int j = 0; j < rd_lat + 1; j++) exp_trace.push_back({1'b0, 4'(a)});
        if (EL_HASWR[e]) exp_trace.push_back({1'b1, 4'(a)});
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, bad;
    bit r_fail;
    int r_elem, r_addr, r_cycles;
    logic [7:0] r_data;

    vecs[0] = '{"fault_free",     0, 4'd0,  3'd0, 1'b0, 4'd0, 4'd0,  1'b0, 3'd0, 4'd0,  8'h00, 240};
    vecs[1] = '{"sa0_b3_a5",      1, 4'd5,  3'd3, 1'b0, 4'd0, 4'd0,  1'b1, 3'd2, 4'd5,  8'h08, 81};
    vecs[2] = '{"alias_3_to_11",  2, 4'd0,  3'd0, 1'b0, 4'd3, 4'd11, 1'b1, 3'd1, 4'd11, 8'hFF, 51};
    vecs[3] = '{"sa1_b0_a0",      1, 4'd0,  3'd0, 1'b1, 4'd0, 4'd0,  1'b1, 3'd1, 4'd0,  8'h01, 18};
    vecs[4] = '{"sa0_b7_a15",     1, 4'd15, 3'd7, 1'b0, 4'd0, 4'd0,  1'b1, 3'd2, 4'd15, 8'h80, 111};
    vecs[5] = '{"alias_9_to_2",   2, 4'd0,  3'd0, 1'b0, 4'd9, 4'd2,  1'b1, 3'd3, 4'd2,  8'hFF, 153};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs0", {busy0, done0, fail0, fail_elem0, fail_addr0, fail_data0,
                ram0.bist_cs, ram0.bist_we, ram0.bist_addr, ram0.bist_wdata}, 32'd0);
    checkOutput("reset_outputs1", {busy1, done1, fail1, fail_elem1, fail_addr1, fail_data1,
                ram1.bist_cs, ram1.bist_we, ram1.bist_addr, ram1.bist_wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_access", {busy0, done0, ram0.bist_cs, busy1, done1, ram1.bist_cs}, 32'd0);

    $display("[TB] table-driven fault vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      runBist(0, 1'b0, -1, cyc);
      checkOutput({vecs[i].name, "_done"},   {31'd0, done0}, 32'd1);
      checkOutput({vecs[i].name, "_fail"},   {31'd0, fail0}, {31'd0, vecs[i].e_fail});
      checkOutput({vecs[i].name, "_elem"},   {29'd0, fail_elem0}, {29'd0, vecs[i].e_elem});
      checkOutput({vecs[i].name, "_addr"},   {28'd0, fail_addr0}, {28'd0, vecs[i].e_addr});
      checkOutput({vecs[i].name, "_data"},   {24'd0, fail_data0}, {24'd0, vecs[i].e_data});
      checkOutput({vecs[i].name, "_cycles"}, cyc, vecs[i].e_cycles);
    end

    $display("[TB] randomized faults against reference model");
    for (int i = 0; i < 12; i++) begin
      fault_kind = 1 + int'($urandom_range(0, 1));
      f_addr = 4'($urandom_range(0, 15));
      f_bit  = 3'($urandom_range(0, 7));
      f_val  = 1'($urandom_range(0, 1));
      a_src  = 4'($urandom_range(0, 15));
      a_dst  = a_src + 4'($urandom_range(1, 15));
      refMarch(16, 1, r_fail, r_elem, r_addr, r_data, r_cycles);
      runBist(0, 1'b0, -1, cyc);
      checkOutput("rand_fail",   {31'd0, fail0}, {31'd0, r_fail});
      checkOutput("rand_cycles", cyc, r_cycles);
      if (r_fail) begin
        checkOutput("rand_elem", {29'd0, fail_elem0}, r_elem);
        checkOutput("rand_addr", {28'd0, fail_addr0}, r_addr);
        checkOutput("rand_data", {24'd0, fail_data0}, {24'd0, r_data});
      end
    end
    fault_kind = 0;

    $display("[TB] asynchronous reset during M2");
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (70) @(negedge clk);
    checkOutput("pre_reset_busy", {31'd0, busy0}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {busy0, done0, fail0, fail_elem0, fail_addr0, fail_data0,
                ram0.bist_cs, ram0.bist_we, ram0.bist_addr, ram0.bist_wdata}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    runBist(0, 1'b0, -1, cyc);
    checkOutput("post_reset_cycles", cyc, 240);
    checkOutput("post_reset_fail", {31'd0, fail0}, 32'd0);

    $display("[TB] start while busy, then start held high");
    runBist(0, 1'b0, 100, cyc);
    checkOutput("ignored_start_cycles", cyc, 240);
    runBist(0, 1'b1, -1, cyc);
    checkOutput("held_first_cycles", cyc, 240);
    checkOutput("held_done", {31'd0, done0}, 32'd1);
    @(negedge clk);
    checkOutput("held_restart_next_cycle", {30'd0, busy0, done0}, 32'd2);
    start0 = 1'b0;
    cyc = 1;
    bad = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done0) begin bad = 0; break; end
      if (busy0) cyc++;
    end
    checkOutput("held_second_timeout", bad, 0);
    checkOutput("held_second_cycles", cyc, 240);

    $display("[TB] RD_LAT=2, SIZE=12 engine");
    act_trace.delete();
    trace_on = 1'b1;
    runBist(1, 1'b0, -1, cyc);
    trace_on = 1'b0;
    checkOutput("lat2_cycles", cyc, 240);
    checkOutput("lat2_fail", {31'd0, fail1}, 32'd0);
    buildTrace(12, 2);
    checkOutput("lat2_trace_len", act_trace.size(), exp_trace.size());
    bad = 0;
    for (int i = 0; i < exp_trace.size() && i < act_trace.size(); i++)
      if (act_trace[i] !== exp_trace[i]) bad++;
    checkOutput("lat2_trace_diff", bad, 0);
    if (act_trace.size() > 152) begin
      checkOutput("lat2_m0_first_addr", {27'd0, act_trace[0]},   {27'd0, 5'h10});
      checkOutput("lat2_m0_last_addr",  {27'd0, act_trace[11]},  {27'd0, 5'h1B});
      checkOutput("lat2_m3_first_addr", {27'd0, act_trace[108]}, {27'd0, 5'h0B});
      checkOutput("lat2_m3_last_addr",  {27'd0, act_trace[152]}, {27'd0, 5'h00});
    end else begin
      checkOutput("lat2_trace_short", act_trace.size(), 153);
    end

    checkOutput("bus_interlock", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
